mac_postproc: RTL

Output post-processing stage placed directly downstream of the `mac` dot-product unit. It consumes the 20-bit signed partial sums `mac` emits (one per `vld_o` pulse), accumulates a configurable number of them into one output-channel value, adds bias, applies activation, round-shifts and saturates to int8. Results queue in a small FIFO drained by a valid/ready handshake toward the write-back path.

---
 rtl/mac_postproc.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mac_postproc.sv
// Post-processing stage after the mac unit: accumulate partial sums, add bias, activate, round-shift, saturate to int8, queue in a FWFT FIFO.
// Build option: define MAC_POSTPROC_LEAKY_EN for leaky activation (s>>>3); otherwise activation is ReLU.
module mac_postproc #(
    parameter int ACC_IN_W   = 20,
    parameter int PSUM_W     = 32,
    parameter int OUT_W      = 8,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vld_i,
    input  logic [ACC_IN_W-1:0] acc_i,
    input  logic [CNT_W-1:0]    cfg_num_psum,
    input  logic [PSUM_W-1:0]   cfg_bias,
    input  logic [4:0]          cfg_shift,
    input  logic                cfg_act_en,
    input  logic                rdy_i,
    output logic                vld_o,
    output logic [OUT_W-1:0]    dout,
    output logic                ovf_o,
    output logic                busy
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int QMAX = (2 ** (OUT_W - 1)) - 1;
    localparam int QMIN = -(2 ** (OUT_W - 1));

    logic [CNT_W-1:0]         cnt_r, cnt_s, n_sh_r, n_sh_s, n_eff_s, grp_n_s;
    logic signed [PSUM_W-1:0] psum_r, psum_s, acc_ext_s;
    logic [4:0]               shift_sh_r, shift_sh_s, grp_shift_s;
    logic                     act_sh_r, act_sh_s, grp_act_s, last_s;
    logic                     b_vld_r, b_vld_s, b_act_r, b_act_s;
    logic signed [PSUM_W-1:0] b_sum_r, b_sum_s;
    logic [4:0]               b_shift_r, b_shift_s;
    logic [OUT_W-1:0]         mem_r [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr_r, wr_ptr_s, rd_ptr_r, rd_ptr_s;
    logic [AW:0]              count_r, count_s, after_pop_s;
    logic                     pop_s, full_s, push_ok_s;
    logic [OUT_W-1:0]         q_s, dout_r, dout_s;
    logic                     vld_r, vld_s, ovf_r, ovf_s, busy_r, busy_s;

    // Activation, rounding right shift and int8 saturation of one group sum.
    function automatic logic [OUT_W-1:0] quantize(input logic signed [PSUM_W-1:0] s_in,
                                                   input logic [4:0] sh, input logic act);
        logic signed [PSUM_W:0] a, rnd, r;
        a = {s_in[PSUM_W-1], s_in};
        if (act && s_in[PSUM_W-1]) begin
`ifdef MAC_POSTPROC_LEAKY_EN
            a = a >>> 3;
`else
            a = '0;
`endif
        end else begin
            a = a;
        end
        if (sh != 5'd0) begin
            rnd = (PSUM_W + 1)'(1) << (sh - 5'd1);
            r   = (a + rnd) >>> sh;
        end else begin
            r = a;
        end
        if (r > QMAX) begin
            quantize = OUT_W'(QMAX);
        end else if (r < QMIN) begin
            quantize = OUT_W'(QMIN);
        end else begin
            quantize = r[OUT_W-1:0];
        end
    endfunction

    // Next-state logic for accumulator, stage B and FIFO bookkeeping.
    always_comb begin
        acc_ext_s   = {{(PSUM_W - ACC_IN_W){acc_i[ACC_IN_W-1]}}, acc_i};
        n_eff_s     = (cfg_num_psum == '0) ? CNT_W'(1) : cfg_num_psum;
        grp_n_s     = (cnt_r == '0) ? n_eff_s : n_sh_r;
        grp_shift_s = (cnt_r == '0) ? cfg_shift : shift_sh_r;
        grp_act_s   = (cnt_r == '0) ? cfg_act_en : act_sh_r;
        last_s      = (cnt_r == grp_n_s - CNT_W'(1));
        cnt_s       = cnt_r;
        n_sh_s      = n_sh_r;
        shift_sh_s  = shift_sh_r;
        act_sh_s    = act_sh_r;
        psum_s      = psum_r;
        b_vld_s     = 1'b0;
        b_sum_s     = b_sum_r;
        b_shift_s   = b_shift_r;
        b_act_s     = b_act_r;
        if (vld_i) begin
            n_sh_s     = grp_n_s;
            shift_sh_s = grp_shift_s;
            act_sh_s   = grp_act_s;
            psum_s     = ((cnt_r == '0) ? $signed(cfg_bias) : psum_r) + acc_ext_s;
            if (last_s) begin
                cnt_s     = '0;
                b_vld_s   = 1'b1;
                b_sum_s   = psum_s;
                b_shift_s = grp_shift_s;
                b_act_s   = grp_act_s;
            end else begin
                cnt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_s = cnt_r;
        end

        q_s         = quantize(b_sum_r, b_shift_r, b_act_r);
        pop_s       = vld_r && rdy_i;
        full_s      = (count_r == (AW + 1)'(FIFO_DEPTH));
        push_ok_s   = b_vld_r && (!full_s || pop_s);
        ovf_s       = ovf_r || (b_vld_r && full_s && !pop_s);
        wr_ptr_s    = wr_ptr_r + AW'(push_ok_s);
        rd_ptr_s    = rd_ptr_r + AW'(pop_s);
        after_pop_s = count_r - (AW + 1)'(pop_s);
        count_s     = after_pop_s + (AW + 1)'(push_ok_s);
        // When the pop empties the queue, the new head is the word being written this cycle.
        if (count_s == '0) begin
            vld_s  = 1'b0;
            dout_s = '0;
        end else if (after_pop_s == '0) begin
            vld_s  = 1'b1;
            dout_s = q_s;
        end else begin
            vld_s  = 1'b1;
            dout_s = mem_r[rd_ptr_s];
        end
        busy_s = (cnt_s != '0) || b_vld_s || (count_s != '0);
    end

    // Control and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= '0;
            n_sh_r     <= '0;
            shift_sh_r <= 5'd0;
            act_sh_r   <= 1'b0;
            psum_r     <= '0;
            b_vld_r    <= 1'b0;
            b_sum_r    <= '0;
            b_shift_r  <= 5'd0;
            b_act_r    <= 1'b0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            vld_r      <= 1'b0;
            dout_r     <= '0;
            ovf_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            cnt_r      <= cnt_s;
            n_sh_r     <= n_sh_s;
            shift_sh_r <= shift_sh_s;
            act_sh_r   <= act_sh_s;
            psum_r     <= psum_s;
            b_vld_r    <= b_vld_s;
            b_sum_r    <= b_sum_s;
            b_shift_r  <= b_shift_s;
            b_act_r    <= b_act_s;
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            count_r    <= count_s;
            vld_r      <= vld_s;
            dout_r     <= dout_s;
            ovf_r      <= ovf_s;
            busy_r     <= busy_s;
        end
    end

    // FIFO storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (!rst && push_ok_s) begin
            mem_r[wr_ptr_r] <= q_s;
        end
    end

    assign vld_o = vld_r;
    assign dout  = dout_r;
    assign ovf_o = ovf_r;
    assign busy  = busy_r;
endmodule
